// File: rtl/cordic_iter_engine.sv
// Iterative Q5.10 CORDIC engine (linear / hyperbolic rotation) driving an external constant ROM.
// Define CORDIC_SAT_EN to make every x/y/z add saturate; otherwise adds wrap modulo 2^(WIDTH+1).
module cordic_iter_engine #(
  parameter int unsigned WIDTH = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic signed [WIDTH:0] x_in,
  input  logic signed [WIDTH:0] y_in,
  input  logic signed [WIDTH:0] z_in,
  output logic                rom_sel,
  output logic [3:0]          rom_idx,
  input  logic signed [WIDTH:0] rom_data,
  output logic signed [WIDTH:0] x_out,
  output logic signed [WIDTH:0] y_out,
  output logic signed [WIDTH:0] z_out,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] FIRST_IDX = 4'd1;
  localparam logic [3:0] LAST_IDX  = 4'd10;
  localparam logic [3:0] REP_IDX   = 4'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic                mode_q, mode_next;
  logic                rep_q, rep_next;
  logic [3:0]          idx_next;
  logic                sel_next;
  logic                busy_next, done_next;
  logic signed [WIDTH:0] x_next, y_next, z_next;

  logic                neg;
  logic [3:0]          shift;
  logic signed [WIDTH:0] x_sh, y_sh, x_upd, y_upd, z_upd;

  // a + b or a - b at word width, saturating or wrapping by build option
  function automatic logic signed [WIDTH:0] add_sub(input logic signed [WIDTH:0] a,
                                                    input logic signed [WIDTH:0] b,
                                                    input logic sub);
`ifdef CORDIC_SAT_EN
    logic [WIDTH+1:0] sum;
    sum = sub ? ({a[WIDTH], a} - {b[WIDTH], b}) : ({a[WIDTH], a} + {b[WIDTH], b});
    if (sum[WIDTH+1] != sum[WIDTH]) begin
      return sum[WIDTH+1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, {WIDTH{1'b1}}};
    end
    return sum[WIDTH:0];
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  // One micro-rotation from the current working registers; d = -1 when z is negative
  always_comb begin
    neg   = z_out[WIDTH];
    shift = mode_q ? rom_idx : (rom_idx - 4'd1);
    x_sh  = x_out >>> shift;
    y_sh  = y_out >>> shift;
    y_upd = add_sub(y_out, x_sh, neg);
    x_upd = mode_q ? add_sub(x_out, y_sh, neg) : x_out;
    z_upd = add_sub(z_out, rom_data, ~neg);
  end

  always_comb begin
    state_next = state;
    mode_next  = mode_q;
    rep_next   = rep_q;
    idx_next   = rom_idx;
    sel_next   = rom_sel;
    busy_next  = busy;
    done_next  = 1'b0;
    x_next     = x_out;
    y_next     = y_out;
    z_next     = z_out;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          mode_next  = mode;
          rep_next   = 1'b0;
          idx_next   = FIRST_IDX;
          sel_next   = mode;
          busy_next  = 1'b1;
          x_next     = x_in;
          y_next     = y_in;
          z_next     = z_in;
        end else begin
          state_next = IDLE;
          idx_next   = FIRST_IDX;
          sel_next   = 1'b0;
          busy_next  = 1'b0;
        end
      end
      RUN: begin
        x_next = x_upd;
        y_next = y_upd;
        z_next = z_upd;
        if (rom_idx == LAST_IDX) begin
          state_next = DONE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          idx_next   = FIRST_IDX;
          sel_next   = 1'b0;
        end else if (mode_q && (rom_idx == REP_IDX) && !rep_q) begin
          // hyperbolic convergence needs index 4 applied twice
          rep_next = 1'b1;
        end else begin
          idx_next = rom_idx + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = FIRST_IDX;
        sel_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      rep_q   <= 1'b0;
      rom_idx <= FIRST_IDX;
      rom_sel <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      z_out   <= '0;
    end else begin
      state   <= state_next;
      mode_q  <= mode_next;
      rep_q   <= rep_next;
      rom_idx <= idx_next;
      rom_sel <= sel_next;
      busy    <= busy_next;
      done    <= done_next;
      x_out   <= x_next;
      y_out   <= y_next;
      z_out   <= z_next;
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: directed plan cases plus random runs against an integer CORDIC model.
module tb_cordic_iter_engine;

  logic               clk = 1'b0;
  logic               rst_n, start, mode;
  logic signed [15:0] x_in, y_in, z_in, rom_data;
  logic signed [15:0] x_out, y_out, z_out;
  logic               rom_sel, busy, done;
  logic [3:0]         rom_idx;

  int errors = 0;
  int checks = 0;
  int obs_idx [0:31];
  int obs_sel [0:31];
  int done_at;

  always #5 clk = ~clk;

  cordic_iter_engine #(.WIDTH(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .rom_sel(rom_sel), .rom_idx(rom_idx), .rom_data(rom_data),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .busy(busy), .done(done)
  );

  // Constant ROM: linear 2^-(i-1), hyperbolic atanh(2^-i), both in Q5.10
  function automatic int rom_value(input logic sel, input logic [3:0] idx);
    if (idx < 4'd1 || idx > 4'd10) return 0;
    if (!sel) return 1024 >> (int'(idx) - 1);
    case (idx)
      4'd1: return 562;
      4'd2: return 262;
      4'd3: return 129;
      4'd4: return 64;
      4'd5: return 32;
      4'd6: return 16;
      4'd7: return 8;
      4'd8: return 4;
      4'd9: return 2;
      default: return 1;
    endcase
  endfunction

  always_comb rom_data = 16'(rom_value(rom_sel, rom_idx));

  function automatic int norm(input int v);
`ifdef CORDIC_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
`endif
  endfunction

  function automatic int sched_len(input bit m);
    return m ? 11 : 10;
  endfunction

  // k-th ROM index (1-based) of the iteration schedule
  function automatic int sched_idx(input bit m, input int k);
    if (!m) return k;
    return (k <= 4) ? k : k - 1;
  endfunction

  task automatic model(input bit m, input int x0, input int y0, input int z0,
                       output int xr, output int yr, output int zr);
    int x, y, z, xn, yn, zn, idx, s, d;
    x = x0; y = y0; z = z0;
    for (int k = 1; k <= sched_len(m); k++) begin
      idx = sched_idx(m, k);
      s   = m ? idx : idx - 1;
      d   = (z >= 0) ? 1 : -1;
      xn  = m ? norm(x + d * (y >>> s)) : x;
      yn  = norm(y + d * (x >>> s));
      zn  = norm(z - d * rom_value(m, 4'(idx)));
      x = xn; y = yn; z = zn;
    end
    xr = x; yr = y; zr = z;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit m, input int x, input int y, input int z);
    start = 1'b1; mode = m;
    x_in = 16'(x); y_in = 16'(y); z_in = 16'(z);
    step();
  endtask

  // Records rom_idx/rom_sel per cycle until done or the cycle budget runs out
  task automatic collect(input int maxc);
    done_at = 0;
    for (int c = 1; c <= maxc; c++) begin
      obs_idx[c] = int'(rom_idx);
      obs_sel[c] = int'(rom_sel);
      step();
      if (done) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; mode = 1'b1;
    x_in = 16'(1000); y_in = 16'(-7); z_in = 16'(300);
    step(); step();
    checks++;
    if (x_out !== 16'sd0 || y_out !== 16'sd0 || z_out !== 16'sd0) begin
      errors++; $display("FAIL reset_xyz: got %0d %0d %0d want 0 0 0", x_out, y_out, z_out);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_idx !== 4'd1 || rom_sel !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b done=%b idx=%0d sel=%b want 0 0 1 0", busy, done, rom_idx, rom_sel);
    end
    start = 1'b0; rst_n = 1'b1;
    step();
  endtask

  task automatic test_linear_multiply();
    int xr, yr, zr;
    model(1'b0, 1536, 0, 512, xr, yr, zr);
    launch(1'b0, 1536, 0, 512);
    start = 1'b0; x_in = 16'($urandom); z_in = 16'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL lin_busy_at_T: busy=%b done=%b want 1 0", busy, done);
    end
    collect(20);
    checks++;
    if (done_at !== 10) begin errors++; $display("FAIL lin_latency: got %0d want 10", done_at); end
    checks++;
    if (x_out !== 16'sd1536) begin errors++; $display("FAIL lin_x: got %0d want 1536", x_out); end
    checks++;
    if (y_out !== 16'(yr)) begin errors++; $display("FAIL lin_y: got %0d want %0d", y_out, yr); end
    checks++;
    if (int'(z_out) > 2 || int'(z_out) < -2 || z_out !== 16'(zr)) begin
      errors++; $display("FAIL lin_z: got %0d want %0d (|z|<=2)", z_out, zr);
    end
    step();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL lin_done_pulse: done=%b want 0", done); end
  endtask

  task automatic test_hyperbolic();
    int xr, yr, zr;
    model(1'b1, 1237, 0, 512, xr, yr, zr);
    launch(1'b1, 1237, 0, 512);
    start = 1'b0;
    collect(20);
    checks++;
    if (done_at !== 11) begin errors++; $display("FAIL hyp_latency: got %0d want 11", done_at); end
    checks++;
    if (int'(x_out) < 1151 || int'(x_out) > 1159 || x_out !== 16'(xr)) begin
      errors++; $display("FAIL hyp_cosh: got %0d want %0d (1155+-4)", x_out, xr);
    end
    checks++;
    if (int'(y_out) < 530 || int'(y_out) > 538 || y_out !== 16'(yr)) begin
      errors++; $display("FAIL hyp_sinh: got %0d want %0d (534+-4)", y_out, yr);
    end
    checks++;
    if (z_out !== 16'(zr)) begin errors++; $display("FAIL hyp_z: got %0d want %0d", z_out, zr); end
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if (obs_idx[k] !== sched_idx(1'b1, k) || obs_sel[k] !== 1) begin
        errors++; $display("FAIL hyp_schedule[%0d]: idx=%0d sel=%0d want %0d 1", k, obs_idx[k], obs_sel[k], sched_idx(1'b1, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int xa, ya, za, xb, yb, zb;
    bit sched_ok;
    model(1'b0, -2048, 300, -700, xa, ya, za);
    model(1'b1, 1237, 100, -400, xb, yb, zb);
    launch(1'b0, -2048, 300, -700);
    // start stays high and mode flips while busy; neither may disturb the run
    mode = 1'b1; x_in = 16'(5); y_in = 16'(6); z_in = 16'(7);
    collect(20);
    checks++;
    if (done_at !== 10) begin errors++; $display("FAIL b2b_first_latency: got %0d want 10", done_at); end
    sched_ok = 1'b1;
    for (int k = 1; k <= 10; k++) if (obs_idx[k] !== k || obs_sel[k] !== 0) sched_ok = 1'b0;
    checks++;
    if (!sched_ok) begin errors++; $display("FAIL b2b_no_restart: schedule ok=%0d want 1", sched_ok); end
    checks++;
    if (x_out !== 16'(xa) || y_out !== 16'(ya) || z_out !== 16'(za)) begin
      errors++; $display("FAIL b2b_first_result: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, xa, ya, za);
    end
    // start is still high in the DONE cycle: accepted immediately
    mode = 1'b1; x_in = 16'(1237); y_in = 16'(100); z_in = 16'(-400);
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || rom_sel !== 1'b1 || rom_idx !== 4'd1) begin
      errors++; $display("FAIL b2b_restart: busy=%b done=%b sel=%b idx=%0d want 1 0 1 1", busy, done, rom_sel, rom_idx);
    end
    collect(20);
    checks++;
    if (done_at !== 11) begin errors++; $display("FAIL b2b_second_latency: got %0d want 11", done_at); end
    checks++;
    if (x_out !== 16'(xb) || y_out !== 16'(yb) || z_out !== 16'(zb)) begin
      errors++; $display("FAIL b2b_second_result: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, xb, yb, zb);
    end
    for (int c = 0; c < 3; c++) begin
      x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
      step();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_idx !== 4'd1 || rom_sel !== 1'b0
        || x_out !== 16'(xb) || y_out !== 16'(yb) || z_out !== 16'(zb)) begin
      errors++; $display("FAIL idle_hold: busy=%b done=%b idx=%0d sel=%b xyz=%0d %0d %0d want 0 0 1 0 %0d %0d %0d",
                         busy, done, rom_idx, rom_sel, x_out, y_out, z_out, xb, yb, zb);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_done, seen_busy;
    launch(1'b1, 1237, 0, 512);
    start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (x_out !== 16'sd0 || y_out !== 16'sd0 || z_out !== 16'sd0 || busy !== 1'b0 || done !== 1'b0
        || rom_idx !== 4'd1 || rom_sel !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: xyz=%0d %0d %0d busy=%b done=%b idx=%0d sel=%b want 0 0 0 0 0 1 0",
                         x_out, y_out, z_out, busy, done, rom_idx, rom_sel);
    end
    rst_n = 1'b1;
    seen_done = 0; seen_busy = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    checks++;
    if (seen_done !== 0 || seen_busy !== 0) begin
      errors++; $display("FAIL midrun_no_done: done_cycles=%0d busy_cycles=%0d want 0 0", seen_done, seen_busy);
    end
  endtask

  task automatic test_overflow();
    int xr, yr, zr;
    model(1'b0, 31744, 0, 1946, xr, yr, zr);
    launch(1'b0, 31744, 0, 1946);
    start = 1'b0;
    collect(20);
    checks++;
    if (done_at !== 10) begin errors++; $display("FAIL ovf_latency: got %0d want 10", done_at); end
    checks++;
    if (x_out !== 16'(xr) || y_out !== 16'(yr) || z_out !== 16'(zr)) begin
      errors++; $display("FAIL ovf_result: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, xr, yr, zr);
    end
  endtask

  task automatic test_random();
    int xr, yr, zr, x0, y0, z0;
    bit m, sched_ok;
    for (int n = 0; n < 24; n++) begin
      m  = 1'($urandom);
      x0 = int'($signed(16'($urandom)));
      y0 = int'($signed(16'($urandom)));
      z0 = (n < 12) ? $urandom_range(2200) - 1100 : int'($signed(16'($urandom)));
      model(m, x0, y0, z0, xr, yr, zr);
      launch(m, x0, y0, z0);
      start = 1'b0; mode = 1'($urandom);
      collect(20);
      checks++;
      if (done_at !== sched_len(m)) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, done_at, sched_len(m));
      end
      sched_ok = 1'b1;
      for (int k = 1; k <= sched_len(m); k++)
        if (obs_idx[k] !== sched_idx(m, k) || obs_sel[k] !== int'(m)) sched_ok = 1'b0;
      checks++;
      if (!sched_ok) begin errors++; $display("FAIL rand_schedule[%0d]: ok=%0d want 1", n, sched_ok); end
      checks++;
      if (x_out !== 16'(xr) || y_out !== 16'(yr) || z_out !== 16'(zr)) begin
        errors++; $display("FAIL rand_result[%0d] m=%0d in=%0d %0d %0d: got %0d %0d %0d want %0d %0d %0d",
                           n, m, x0, y0, z0, x_out, y_out, z_out, xr, yr, zr);
      end
      if ($urandom_range(1) == 1) step();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    test_reset();
    test_linear_multiply();
    test_hyperbolic();
    test_back_to_back();
    test_reset_mid_run();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
